// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if
//   Groups the keypad matrix lines and the decoded key outputs of the
//   keypad scan controller.
//   col       : keypad column lines, active-low (driven by the keypad side)
//   row       : one-hot active-low row drive (driven by the controller)
//   key_code  : row_index*4 + col_index of the last accepted key
//   key_valid : one-cycle pulse for each newly accepted key
//   key_held  : high while the accepted key has not been accepted as released
//   Modports: master = controller side, slave = keypad/consumer side.
interface keypad_scan_ctrl_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  col,
    output row,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output col,
    input  row,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   4x4 keypad scanner with press/release debouncing. One row is driven
//   low per cycle; while no column is low the active row rotates. A detected
//   column must be seen on N consecutive samples before the key is accepted,
//   and N consecutive idle samples are needed before the release is accepted.
//   Ports:
//     clk_1000hz : 1 kHz scan/sample clock, all state changes on rising edge
//     rst_n      : asynchronous active-low reset
//     kp         : keypad_scan_ctrl_if.master (col in; row, key_code,
//                  key_valid, key_held out)
//   Parameter N (2..15): consecutive matching samples for press and release.
module keypad_scan_ctrl #(
  parameter int N = 5
) (
  input  logic                      clk_1000hz,
  input  logic                      rst_n,
  keypad_scan_ctrl_if.master        kp
);

  localparam logic [3:0] N_L = 4'(N);

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] r_q, r_d;
  logic [3:0] row_q, row_d;
  logic [1:0] cc_q, cc_d;
  logic [3:0] match_q, match_d;
  logic [3:0] rel_q, rel_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;

  logic       key_any;
  logic [1:0] col_idx;
  logic       same_col;
  logic [3:0] match_inc;
  logic [3:0] rel_inc;

  // Column decode: lowest-index low column wins when several are low.
  always_comb begin
    key_any = (kp.col != 4'hF);
    if (!kp.col[0])      col_idx = 2'd0;
    else if (!kp.col[1]) col_idx = 2'd1;
    else if (!kp.col[2]) col_idx = 2'd2;
    else                 col_idx = 2'd3;
    same_col = key_any && (col_idx == cc_q);
  end

  // Saturating increments so neither counter can run past N.
  always_comb begin
    match_inc = (match_q >= N_L) ? N_L : match_q + 4'd1;
    rel_inc   = (rel_q   >= N_L) ? N_L : rel_q   + 4'd1;
  end

  // State register
  always_ff @(posedge clk_1000hz or negedge rst_n) begin
    if (!rst_n) state_q <= SCAN;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCAN: begin
        if (key_any) state_d = CONFIRM;
      end
      CONFIRM: begin
        if (!same_col)               state_d = SCAN;
        else if (match_inc == N_L)   state_d = HOLD;
      end
      HOLD: begin
        if (!key_any && (rel_inc == N_L)) state_d = SCAN;
      end
      default: state_d = SCAN;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    r_d     = r_q;
    cc_d    = cc_q;
    match_d = match_q;
    rel_d   = rel_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    unique case (state_q)
      SCAN: begin
        if (!key_any) begin
          r_d = r_q + 2'd1;
        end else begin
          cc_d    = col_idx;
          match_d = 4'd1;
        end
      end
      CONFIRM: begin
        if (same_col) begin
          match_d = match_inc;
          if (match_inc == N_L) begin
            // {row, col} is exactly row*4 + col.
            code_d  = {r_q, cc_q};
            valid_d = 1'b1;
            held_d  = 1'b1;
            match_d = 4'd0;
          end
        end else begin
          match_d = 4'd0;
          r_d     = r_q + 2'd1;
        end
      end
      HOLD: begin
        // Any low column on the held row, even a different key, means
        // "not released yet".
        if (!key_any) begin
          if (rel_inc == N_L) begin
            held_d = 1'b0;
            rel_d  = 4'd0;
            r_d    = r_q + 2'd1;
          end else begin
            rel_d = rel_inc;
          end
        end else begin
          rel_d = 4'd0;
        end
      end
      default: begin
        match_d = 4'd0;
        rel_d   = 4'd0;
      end
    endcase
    row_d = ~(4'b0001 << r_d);
  end

  // Datapath / output registers
  always_ff @(posedge clk_1000hz or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= 2'd0;
      row_q   <= 4'b1110;
      cc_q    <= 2'd0;
      match_q <= 4'd0;
      rel_q   <= 4'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      r_q     <= r_d;
      row_q   <= row_d;
      cc_q    <= cc_d;
      match_q <= match_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign kp.row       = row_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: a keypad matrix model drives col from the
// set of pressed keys, a behavioural model predicts accepted keys into a
// scoreboard queue, and a monitor compares the DUT every cycle.
module tb_keypad_scan_ctrl;
  localparam int N = 5;
  localparam logic [15:0] K0  = 16'h0001;
  localparam logic [15:0] K6  = 16'h0040;
  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K13 = 16'h2000;
  localparam logic [15:0] K15 = 16'h8000;

  logic        clk_1000hz = 1'b0;
  logic        rst_n      = 1'b0;
  logic [15:0] pressed    = '0;

  keypad_scan_ctrl_if kp_if();

  keypad_scan_ctrl #(.N(N)) dut (
    .clk_1000hz (clk_1000hz),
    .rst_n      (rst_n),
    .kp         (kp_if.master)
  );

  always #5 clk_1000hz = ~clk_1000hz;

  // Keypad matrix: a pressed key pulls its column low when its row is driven.
  always_comb begin
    kp_if.col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (kp_if.row[r] == 1'b0)
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) kp_if.col[c] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int npulse = 0;
  int last_code = 0;

  typedef struct { int code; int edge_no; } exp_t;
  exp_t q[$];

  // Reference model state: phase 0 = looking for a key, 1 = qualifying a
  // press, 2 = key accepted and waiting for release.
  int m_phase = 0, m_r = 0, m_cc = 0, m_run = 0, m_quiet = 0, m_code = 0;
  int m_held = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic int row_of(input int r);
    logic [3:0] v;
    v = 4'hF;
    v[r] = 1'b0;
    return int'(v);
  endfunction

  function automatic int lowest(input logic [3:0] s);
    for (int c = 0; c < 4; c++) if (s[c]) return c;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_r = 0; m_cc = 0; m_run = 0; m_quiet = 0; m_code = 0; m_held = 0;
  endtask

  task automatic model_step();
    logic [3:0] s;
    int c;
    exp_t e;
    for (int k = 0; k < 4; k++) s[k] = pressed[m_r*4+k];
    c = lowest(s);
    case (m_phase)
      0: if (c < 0) m_r = (m_r + 1) % 4;
         else begin m_phase = 1; m_cc = c; m_run = 1; end
      1: if (c == m_cc) begin
           m_run++;
           if (m_run == N) begin
             m_phase = 2; m_code = m_r*4 + m_cc; m_held = 1; m_quiet = 0; m_run = 0;
             e.code = m_code; e.edge_no = edge_cnt + 1;
             q.push_back(e);
           end
         end else begin
           m_phase = 0; m_run = 0; m_r = (m_r + 1) % 4;
         end
      default: if (c < 0) begin
           m_quiet++;
           if (m_quiet == N) begin
             m_phase = 0; m_held = 0; m_quiet = 0; m_r = (m_r + 1) % 4;
           end
         end else m_quiet = 0;
    endcase
  endtask

  // One sample period: key set applied at the falling edge, sampled at the
  // following rising edge.
  task automatic step(input logic [15:0] p);
    @(negedge clk_1000hz);
    pressed = p;
    if (rst_n) model_step();
    else       model_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) step(16'h0000);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(posedge clk_1000hz);
      edge_cnt++;
      #1;
      chk("row", int'(kp_if.row), row_of(m_r));
      chk("key_held", int'(kp_if.key_held), m_held);
      chk("key_code", int'(kp_if.key_code), m_code);
      if (q.size() > 0 && q[0].edge_no == edge_cnt) begin
        chk("key_valid_pulse", int'(kp_if.key_valid), 1);
        chk("pulse_code", int'(kp_if.key_code), q[0].code);
        void'(q.pop_front());
      end else begin
        chk("key_valid_idle", int'(kp_if.key_valid), 0);
      end
      if (kp_if.key_valid) begin
        npulse++;
        last_code = int'(kp_if.key_code);
      end
    end
  end

  // Stimulus
  initial begin
    int base;
    logic [15:0] mask;
    int len;
    int bounce;
    model_reset();
    step(16'h0000);
    step(16'h0000);
    @(posedge clk_1000hz); #2 rst_n = 1'b1;
    idle(4);

    // Clean press of key 6
    base = npulse;
    repeat (30) step(K6);
    idle(12);
    chk("k6_pulses", npulse - base, 1);
    chk("k6_code", last_code, 6);

    // Bouncing key 9, then stable
    base = npulse;
    for (int i = 0; i < 10; i++) step(((i / 2) % 2 == 0) ? K9 : 16'h0000);
    chk("k9_bounce_pulses", npulse - base, 0);
    repeat (20) step(K9);
    idle(12);
    chk("k9_pulses", npulse - base, 1);
    chk("k9_code", last_code, 9);

    // Too-short press of key 0, aligned to row 0 being sampled
    base = npulse;
    for (int i = 0; i < 8 && m_r != 0; i++) step(16'h0000);
    repeat (3) step(K0);
    idle(8);
    chk("k0_short_pulses", npulse - base, 0);
    chk("k0_short_code_kept", int'(kp_if.key_code), 9);

    // Two keys on row 3: lowest column wins
    base = npulse;
    repeat (20) step(K13 | K15);
    idle(12);
    chk("k13_pulses", npulse - base, 1);
    chk("k13_code", last_code, 13);

    // Release glitch during hold
    base = npulse;
    repeat (20) step(K6);
    repeat (3) step(16'h0000);
    step(K6);
    repeat (5) step(16'h0000);
    chk("glitch_held_4idle", int'(kp_if.key_held), 1);
    step(16'h0000);
    chk("glitch_held_5idle", int'(kp_if.key_held), 0);
    idle(8);
    chk("glitch_pulses", npulse - base, 1);

    // Asynchronous reset in the middle of a hold
    base = npulse;
    repeat (20) step(K6);
    chk("pre_rst_held", int'(kp_if.key_held), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_row", int'(kp_if.row), 14);
    chk("rst_held", int'(kp_if.key_held), 0);
    chk("rst_valid", int'(kp_if.key_valid), 0);
    chk("rst_code", int'(kp_if.key_code), 0);
    step(16'h0000);
    step(16'h0000);
    @(posedge clk_1000hz); #2 rst_n = 1'b1;
    step(16'h0000);
    @(posedge clk_1000hz); #2;
    chk("post_rst_row", int'(kp_if.row), 13);
    idle(4);
    chk("rst_pulses", npulse - base, 1);

    // Random presses, with optional bounce at the start
    for (int ep = 0; ep < 40; ep++) begin
      mask = 16'h0001 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) mask = mask | (16'h0001 << $urandom_range(0, 15));
      len = $urandom_range(1, 20);
      bounce = $urandom_range(0, 1);
      for (int i = 0; i < len; i++)
        step((bounce != 0 && i < 6 && $urandom_range(0, 2) == 0) ? 16'h0000 : mask);
      idle($urandom_range(0, 14));
    end
    idle(12);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
